term_cmd_encoder: RTL and testbench



---
 rtl/term_cmd_encoder.sv | 99 +++++++++
 tb/tb_term_cmd_encoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/term_cmd_encoder.sv
// term_cmd_encoder: parses "<letter> [spaces] <digits> CR" lines into one-hot op_code/operand strobes
module term_cmd_encoder #(
    parameter int MAX_DIGITS = 3,
    parameter int OPCODE_W = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [OPCODE_W-1:0] op_code,
    output logic [7:0]          a,
    output logic                cmd_valid,
    output logic                err
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int IW = $clog2(OPCODE_W);
    localparam logic [7:0] LAST = 8'(8'h41 + OPCODE_W - 1);
    typedef enum logic [1:0] {IDLE, DIGITS, ISSUE, DISCARD} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [7:0] acc, acc_n, a_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [11:0] acc_x;
    logic [OPCODE_W-1:0] op_n;
    logic take, is_letter, is_digit, is_cr, is_lf, is_sp, dig_ok, err_n, cv_n, rdy_n;
    assign take = rx_valid && rx_ready;
    assign is_letter = rx_data >= 8'h41 && rx_data <= LAST;
    assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
    assign is_cr = rx_data == 8'h0d;
    assign is_lf = rx_data == 8'h0a;
    assign is_sp = rx_data == 8'h20;
    // Wide enough that acc*10+9 never wraps for any 8-bit acc
    assign acc_x = 12'(acc) * 12'd10 + 12'(rx_data - 8'h30);
    assign dig_ok = acc_x <= 12'd255 && cnt != CW'(MAX_DIGITS);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            acc <= '0;
            cnt <= '0;
            op_code <= '0;
            a <= '0;
            cmd_valid <= 1'b0;
            err <= 1'b0;
            rx_ready <= 1'b1;
        end else begin
            state <= state_n;
            idx <= idx_n;
            acc <= acc_n;
            cnt <= cnt_n;
            op_code <= op_n;
            a <= a_n;
            cmd_valid <= cv_n;
            err <= err_n;
            rx_ready <= rdy_n;
        end
    end
    always_comb begin
        state_n = state;
        idx_n = idx;
        acc_n = acc;
        cnt_n = cnt;
        err_n = 1'b0;
        if (state == ISSUE)
            state_n = IDLE;
        else if (take)
            case (state)
                IDLE:
                    if (is_letter) begin
                        state_n = DIGITS;
                        idx_n = IW'(rx_data - 8'h41);
                        acc_n = '0;
                        cnt_n = '0;
                    end else if (!is_cr && !is_lf) begin
                        state_n = DISCARD;
                        err_n = 1'b1;
                    end
                DIGITS:
                    if (is_digit && dig_ok) begin
                        acc_n = acc_x[7:0];
                        cnt_n = cnt + 1'b1;
                    end else if (is_cr)
                        state_n = ISSUE;
                    else if (!(is_sp && cnt == '0)) begin
                        state_n = DISCARD;
                        err_n = 1'b1;
                    end
                DISCARD: state_n = is_cr ? IDLE : DISCARD;
                default: ;
            endcase
    end
    always_comb begin
        rdy_n = state_n != ISSUE;
        cv_n = state == DIGITS && state_n == ISSUE;
        op_n = cv_n ? OPCODE_W'(1) << idx : '0;
        a_n = cv_n ? acc : a;
    end
endmodule

// File: tb/tb_term_cmd_encoder.sv
// tb_term_cmd_encoder: line-level reference model plus directed command strings
module tb_term_cmd_encoder;
    logic clk = 0, rst = 1, rx_valid = 0, rx_ready, cmd_valid, err;
    logic [7:0] rx_data = 0, a;
    logic [10:0] op_code;
    int total = 0, bad = 0, nerr = 0;
    logic [18:0] log_q[$];
    logic [10:0] m_op = 0;
    logic [7:0] m_a = 0;
    bit m_cv = 0, m_err = 0, m_ready = 1, m_bad = 0;
    logic [7:0] line[$];

    term_cmd_encoder dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .op_code(op_code), .a(a), .cmd_valid(cmd_valid), .err(err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // True when q could still grow into a legal command; val is its numeric operand
    function automatic bit ok_prefix(input logic [7:0] q[$], output int val);
        int i = 1;
        int nd = 0;
        val = 0;
        if (q.size() == 0) return 1;
        if (q[0] < 8'h41 || q[0] > 8'h4b) return 0;
        while (i < q.size() && q[i] == 8'h20) i++;
        for (; i < q.size(); i++) begin
            if (q[i] < 8'h30 || q[i] > 8'h39) return 0;
            val = val * 10 + int'(q[i] - 8'h30);
            nd++;
        end
        return nd <= 3 && val <= 255;
    endfunction

    task automatic model_reset();
        m_op = 0; m_a = 0; m_cv = 0; m_err = 0; m_ready = 1; m_bad = 0;
        line.delete();
    endtask

    task automatic model_edge(input bit acc, input logic [7:0] b);
        int v;
        m_cv = 0; m_err = 0; m_op = 0; m_ready = 1;
        if (!acc) return;
        if (m_bad) begin
            if (b == 8'h0d) m_bad = 0;
        end else if (b == 8'h0d) begin
            if (line.size() != 0) begin
                void'(ok_prefix(line, v));
                m_op = 11'(1) << (line[0] - 8'h41);
                m_a = 8'(v);
                m_cv = 1;
                m_ready = 0;
                line.delete();
            end
        end else if (!(line.size() == 0 && b == 8'h0a)) begin
            line.push_back(b);
            if (!ok_prefix(line, v)) begin
                m_err = 1;
                m_bad = 1;
                line.delete();
            end
        end
    endtask

    task automatic step(output bit took);
        took = rx_valid && m_ready;
        @(posedge clk);
        #1;
        model_edge(took, rx_data);
    endtask

    task automatic idle(int n);
        bit t;
        rx_valid = 0;
        repeat (n) step(t);
    endtask

    task automatic send(string s, bit gaps);
        bit t;
        int n;
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) begin
                rx_valid = 0;
                repeat ($urandom_range(0, 2)) step(t);
            end
            rx_valid = 1;
            rx_data = s[i];
            n = 0;
            do begin
                step(t);
                n++;
            end while (!t && n < 4);
            if (!t) chk("byte_accept", 0, 1);
        end
        rx_valid = 0;
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("op_code", op_code, m_op);
            chk("a", a, m_a);
            chk("cmd_valid", cmd_valid, m_cv);
            chk("err", err, m_err);
            chk("rx_ready", rx_ready, m_ready);
            if (cmd_valid) log_q.push_back({op_code, a});
            if (err) nerr++;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        chk("rst_op", op_code, 0);
        chk("rst_cv", cmd_valid, 0);
        chk("rst_ready", rx_ready, 1);
        rst = 0;
        idle(2);
        send("H5\015", 0);
        idle(2);
        chk("h5_cnt", log_q.size(), 1);
        chk("h5_op", log_q[0][18:8], 11'b00010000000);
        chk("h5_a", log_q[0][7:0], 5);
        send("A255\015K 7\015", 0);
        idle(2);
        chk("ak_cnt", log_q.size(), 3);
        chk("a255_op", log_q[1][18:8], 11'b00000000001);
        chk("a255_a", log_q[1][7:0], 255);
        chk("k7_op", log_q[2][18:8], 11'b10000000000);
        chk("k7_a", log_q[2][7:0], 7);
        send("B256\015", 0);
        idle(2);
        chk("b256_err", nerr, 1);
        chk("b256_nocmd", log_q.size(), 3);
        chk("b256_a_held", a, 7);
        send("C\015", 0);
        idle(2);
        chk("c_op", log_q[3][18:8], 11'b00000000100);
        chk("c_a", log_q[3][7:0], 0);
        send("Z12\015H1234\015", 0);
        idle(2);
        chk("zh_err", nerr, 3);
        chk("zh_nocmd", log_q.size(), 4);
        send("H3\015", 0);
        idle(2);
        chk("h3_op", log_q[4][18:8], 11'b00010000000);
        chk("h3_a", log_q[4][7:0], 3);
        send("\012E 42\015F007\015G\015", 1);
        idle(2);
        chk("gap_cnt", log_q.size(), 8);
        chk("e_op", log_q[5][18:8], 11'b00000010000);
        chk("e_a", log_q[5][7:0], 42);
        chk("f_a", log_q[6][7:0], 7);
        chk("g_op", log_q[7][18:8], 11'b00001000000);
        send("J 1 2\015a1\015D12x\015", 1);
        idle(2);
        chk("misc_err", nerr, 6);
        chk("misc_nocmd", log_q.size(), 8);
        send("H2", 0);
        #2;
        rst = 1;
        model_reset();
        #1;
        chk("arst_op", op_code, 0);
        chk("arst_a", a, 0);
        chk("arst_ready", rx_ready, 1);
        @(posedge clk);
        #1;
        rst = 0;
        send("\015", 0);
        idle(3);
        chk("cr_only", log_q.size(), 8);
        send("D9\015", 0);
        idle(2);
        chk("d9_op", log_q[8][18:8], 11'b00000001000);
        chk("d9_a", log_q[8][7:0], 9);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
